// File: rtl/traffic_light_ctrl_if.sv
// Pedestrian-crossing controller signal bundle.
// The controller side uses the slave modport; the side that supplies the
// button/night requests and observes the lamps uses the master modport.
interface traffic_light_ctrl_if;
    logic       i_w_ped_req;
    logic       i_w_night;
    logic [2:0] o_r_car;
    logic [1:0] o_r_ped;
    logic       o_r_ped_wait;
    logic [2:0] o_r_state;

    modport master (
        output i_w_ped_req,
        output i_w_night,
        input  o_r_car,
        input  o_r_ped,
        input  o_r_ped_wait,
        input  o_r_state
    );

    modport slave (
        input  i_w_ped_req,
        input  i_w_night,
        output o_r_car,
        output o_r_ped,
        output o_r_ped_wait,
        output o_r_state
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Pedestrian-crossing traffic-light controller.
// A free-running prescaler gives a one-cycle tick per time unit; a Moore FSM
// walks the car/pedestrian lamps through tick-counted phases. Lamps are
// registered and decoded from the state/blink values being loaded, so they
// always match the registered state with no input-to-output path.
// Optional night mode (flashing yellow) is built only when the macro
// TL_NIGHT_MODE_EN is defined.
module traffic_light_ctrl #(
    parameter logic [31:0] P_CLK_PER_TICK = 32'd100000000,
    parameter logic [7:0]  P_MIN_GREEN    = 8'd5,
    parameter logic [7:0]  P_YELLOW_TICKS = 8'd3,
    parameter logic [7:0]  P_ALLRED_TICKS = 8'd1,
    parameter logic [7:0]  P_WALK_TICKS   = 8'd8,
    parameter logic [7:0]  P_FLASH_TICKS  = 8'd4
) (
    input  logic                 i_w_clk,
    input  logic                 i_w_reset,
    traffic_light_ctrl_if.slave  tl
);

    typedef enum logic [2:0] {
        S_CAR_GREEN  = 3'd0,
        S_CAR_YELLOW = 3'd1,
        S_ALL_RED1   = 3'd2,
        S_PED_WALK   = 3'd3,
        S_PED_FLASH  = 3'd4,
`ifdef TL_NIGHT_MODE_EN
        S_NIGHT      = 3'd6,
`endif
        S_ALL_RED2   = 3'd5
    } state_t;

    localparam logic [31:0] TICK_LAST    = P_CLK_PER_TICK - 32'd1;
    localparam logic [7:0]  MIN_GREEN_M1 = P_MIN_GREEN - 8'd1;
    localparam logic [7:0]  YELLOW_LAST  = P_YELLOW_TICKS - 8'd1;
    localparam logic [7:0]  ALLRED_LAST  = P_ALLRED_TICKS - 8'd1;
    localparam logic [7:0]  WALK_LAST    = P_WALK_TICKS - 8'd1;
    localparam logic [7:0]  FLASH_LAST   = P_FLASH_TICKS - 8'd1;

    state_t      state_r;
    state_t      base_nxt_s;
    state_t      state_nxt_s;
    logic [31:0] presc_r;
    logic        tick_s;
    logic [7:0]  timer_r;
    logic [7:0]  timer_nxt_s;
    logic        pending_r;
    logic        pending_nxt_s;
    logic        blink_r;
    logic        blink_nxt_s;
    logic        req_ok_s;
    logic        blink_state_s;
    logic [2:0]  car_r;
    logic [2:0]  car_nxt_s;
    logic [1:0]  ped_r;
    logic [1:0]  ped_nxt_s;

    assign tick_s = (presc_r == TICK_LAST);

    // Free-running prescaler; wraps on the tick cycle, independent of the FSM.
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            presc_r <= 32'd0;
        end else if (tick_s) begin
            presc_r <= 32'd0;
        end else begin
            presc_r <= presc_r + 32'd1;
        end
    end

    // Phase sequencing; a timed state exits on the tick that completes its count.
    always_comb begin
        base_nxt_s = state_r;
        case (state_r)
            S_CAR_GREEN: begin
                if (tick_s && pending_r && (timer_r >= MIN_GREEN_M1)) base_nxt_s = S_CAR_YELLOW;
                else                                                  base_nxt_s = S_CAR_GREEN;
            end
            S_CAR_YELLOW: begin
                if (tick_s && (timer_r == YELLOW_LAST)) base_nxt_s = S_ALL_RED1;
                else                                    base_nxt_s = S_CAR_YELLOW;
            end
            S_ALL_RED1: begin
                if (tick_s && (timer_r == ALLRED_LAST)) base_nxt_s = S_PED_WALK;
                else                                    base_nxt_s = S_ALL_RED1;
            end
            S_PED_WALK: begin
                if (tick_s && (timer_r == WALK_LAST)) base_nxt_s = S_PED_FLASH;
                else                                  base_nxt_s = S_PED_WALK;
            end
            S_PED_FLASH: begin
                if (tick_s && (timer_r == FLASH_LAST)) base_nxt_s = S_ALL_RED2;
                else                                   base_nxt_s = S_PED_FLASH;
            end
            S_ALL_RED2: begin
                if (tick_s && (timer_r == ALLRED_LAST)) base_nxt_s = S_CAR_GREEN;
                else                                    base_nxt_s = S_ALL_RED2;
            end
`ifdef TL_NIGHT_MODE_EN
            S_NIGHT: begin
                if (tick_s && !tl.i_w_night) base_nxt_s = S_ALL_RED2;
                else                         base_nxt_s = S_NIGHT;
            end
`endif
            default: base_nxt_s = S_ALL_RED2;
        endcase
`ifdef TL_NIGHT_MODE_EN
        // Night request overrides every phase at the next tick.
        state_nxt_s = (tick_s && tl.i_w_night && (state_r != S_NIGHT)) ? S_NIGHT : base_nxt_s;
`else
        state_nxt_s = base_nxt_s;
`endif
    end

    // Tick timer, request latch and blink phase for the cycle being loaded.
    always_comb begin
        timer_nxt_s   = timer_r;
        pending_nxt_s = pending_r;
        blink_nxt_s   = blink_r;
        req_ok_s      = 1'b0;
        blink_state_s = 1'b0;

        case (state_r)
            S_CAR_GREEN, S_CAR_YELLOW, S_ALL_RED1, S_PED_FLASH, S_ALL_RED2: req_ok_s = 1'b1;
            default:                                                       req_ok_s = 1'b0;
        endcase

        case (state_r)
            S_PED_FLASH: blink_state_s = 1'b1;
`ifdef TL_NIGHT_MODE_EN
            S_NIGHT:     blink_state_s = 1'b1;
`endif
            default:     blink_state_s = 1'b0;
        endcase

        if (state_nxt_s != state_r)              timer_nxt_s = 8'd0;
        else if (tick_s && (timer_r != 8'hFF))   timer_nxt_s = timer_r + 8'd1;
        else                                     timer_nxt_s = timer_r;

        // Entering walk clears the request even if the button is pressed now.
        if ((state_nxt_s == S_PED_WALK) && (state_r != S_PED_WALK)) pending_nxt_s = 1'b0;
`ifdef TL_NIGHT_MODE_EN
        else if (state_r == S_NIGHT)                                pending_nxt_s = 1'b0;
`endif
        else if (tl.i_w_ped_req && req_ok_s)                        pending_nxt_s = 1'b1;
        else                                                        pending_nxt_s = pending_r;

        if ((state_nxt_s != state_r) &&
            ((state_nxt_s == S_PED_FLASH)
`ifdef TL_NIGHT_MODE_EN
             || (state_nxt_s == S_NIGHT)
`endif
            ))                                   blink_nxt_s = 1'b1;
        else if (tick_s && blink_state_s)        blink_nxt_s = ~blink_r;
        else                                     blink_nxt_s = blink_r;
    end

    // Lamp decode of the state and blink values about to be registered.
    always_comb begin
        car_nxt_s = 3'b100;
        ped_nxt_s = 2'b01;
        case (state_nxt_s)
            S_CAR_GREEN:  begin car_nxt_s = 3'b001; ped_nxt_s = 2'b01;            end
            S_CAR_YELLOW: begin car_nxt_s = 3'b010; ped_nxt_s = 2'b01;            end
            S_PED_WALK:   begin car_nxt_s = 3'b100; ped_nxt_s = 2'b10;            end
            S_PED_FLASH:  begin car_nxt_s = 3'b100; ped_nxt_s = {1'b0, blink_nxt_s}; end
`ifdef TL_NIGHT_MODE_EN
            S_NIGHT:      begin car_nxt_s = {1'b0, blink_nxt_s, 1'b0}; ped_nxt_s = 2'b00; end
`endif
            default:      begin car_nxt_s = 3'b100; ped_nxt_s = 2'b01;            end
        endcase
    end

    // State, timer, request, blink and lamp registers.
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            state_r   <= S_ALL_RED2;
            timer_r   <= 8'd0;
            pending_r <= 1'b0;
            blink_r   <= 1'b1;
            car_r     <= 3'b100;
            ped_r     <= 2'b01;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            pending_r <= pending_nxt_s;
            blink_r   <= blink_nxt_s;
            car_r     <= car_nxt_s;
            ped_r     <= ped_nxt_s;
        end
    end

    assign tl.o_r_car      = car_r;
    assign tl.o_r_ped      = ped_r;
    assign tl.o_r_ped_wait = pending_r;
    assign tl.o_r_state    = state_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: directed stimulus pushes the
// expected lamp/state changes (with the clock count at which each appears)
// and a monitor pops and compares whenever the observed outputs change.
module tb_traffic_light_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] car;
        logic [1:0] ped;
        logic       wt;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
        int    cyc;
    } exp_t;

    localparam obs_t RESET_OBS = '{st: 3'd5, car: 3'b100, ped: 2'b01, wt: 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;
    logic inv_en = 1'b0;
    exp_t exp_q[$];
    obs_t prev_r = RESET_OBS;

    always #5 clk = ~clk;

    traffic_light_ctrl_if tl4 ();
    traffic_light_ctrl_if tl3 ();

    traffic_light_ctrl #(.P_CLK_PER_TICK(32'd4)) dut (
        .i_w_clk   (clk),
        .i_w_reset (rst_n),
        .tl        (tl4)
    );

    traffic_light_ctrl #(.P_CLK_PER_TICK(32'd3)) dut3 (
        .i_w_clk   (clk),
        .i_w_reset (rst_n),
        .tl        (tl3)
    );

    // clock edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic void expect_obs(string name, int c, logic [2:0] st,
                                       logic [2:0] car, logic [1:0] ped, logic wt);
        exp_t e;
        e.name   = name;
        e.cyc    = c;
        e.v.st   = st;
        e.v.car  = car;
        e.v.ped  = ped;
        e.v.wt   = wt;
        exp_q.push_back(e);
    endfunction

    function automatic void check_val(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endfunction

    // monitor: compare every change of the main DUT outputs against the queue
    always @(negedge clk) begin
        obs_t cur;
        exp_t e;
        cur = '{st: tl4.o_r_state, car: tl4.o_r_car, ped: tl4.o_r_ped, wt: tl4.o_r_ped_wait};
        if (!rst_n) begin
            prev_r <= RESET_OBS;
        end else begin
            if (cur != prev_r) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_change: cycle %0d state %0d car %b ped %b wait %b",
                             cyc, cur.st, cur.car, cur.ped, cur.wt);
                end else begin
                    e = exp_q.pop_front();
                    if ((cur != e.v) || (cyc != e.cyc)) begin
                        n_errors++;
                        $display("FAIL %s: got cycle %0d state %0d car %b ped %b wait %b, expected cycle %0d state %0d car %b ped %b wait %b",
                                 e.name, cyc, cur.st, cur.car, cur.ped, cur.wt,
                                 e.cyc, e.v.st, e.v.car, e.v.ped, e.v.wt);
                    end
                end
            end
            prev_r <= cur;
            if (inv_en) begin
                n_checks++;
                if ((tl3.o_r_ped[1] && (tl3.o_r_car != 3'b100)) ||
                    (tl3.o_r_car[0] && tl3.o_r_ped[1]) || (tl3.o_r_state == 3'd7)) begin
                    n_errors++;
                    $display("FAIL dut3_safety: cycle %0d car %b ped %b state %0d expected walk only with car 100, state not 7",
                             cyc, tl3.o_r_car, tl3.o_r_ped, tl3.o_r_state);
                end
            end
        end
    end

    // return at the falling edge following rising edge n
    task automatic at_neg(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk_reset(string tag);
        check_val({tag, "_state"}, int'(tl4.o_r_state), 5);
        check_val({tag, "_car"},   int'(tl4.o_r_car),   4);
        check_val({tag, "_ped"},   int'(tl4.o_r_ped),   1);
        check_val({tag, "_wait"},  int'(tl4.o_r_ped_wait), 0);
    endtask

    task automatic drain(string tag);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: %0d expected changes never seen, expected 0 (next %s)",
                     tag, exp_q.size(), exp_q[0].name);
            exp_q.delete();
        end
    endtask

    // asynchronous reset asserted between clock edges
    task automatic async_reset(string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tl4.i_w_ped_req = 1'b0;
        tl4.i_w_night   = 1'b0;
        tl3.i_w_ped_req = 1'b0;
        tl3.i_w_night   = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        // idle: all-red 1 tick then green held 50 ticks
        expect_obs("idle_green", 4, 3'd0, 3'b001, 2'b01, 1'b0);
        at_neg(204);
        drain("idle");

        // single-pulse request early in green: full crossing cycle
        async_reset("rst_b");
        expect_obs("b_green",    4, 3'd0, 3'b001, 2'b01, 1'b0);
        expect_obs("b_wait",     6, 3'd0, 3'b001, 2'b01, 1'b1);
        expect_obs("b_yellow",  24, 3'd1, 3'b010, 2'b01, 1'b1);
        expect_obs("b_allred1", 36, 3'd2, 3'b100, 2'b01, 1'b1);
        expect_obs("b_walk",    40, 3'd3, 3'b100, 2'b10, 1'b0);
        expect_obs("b_flash1",  72, 3'd4, 3'b100, 2'b01, 1'b0);
        expect_obs("b_flash2",  76, 3'd4, 3'b100, 2'b00, 1'b0);
        expect_obs("b_flash3",  80, 3'd4, 3'b100, 2'b01, 1'b0);
        expect_obs("b_flash4",  84, 3'd4, 3'b100, 2'b00, 1'b0);
        expect_obs("b_allred2", 88, 3'd5, 3'b100, 2'b01, 1'b0);
        expect_obs("b_green2",  92, 3'd0, 3'b001, 2'b01, 1'b0);
        at_neg(5);  tl4.i_w_ped_req = 1'b1;
        at_neg(6);  tl4.i_w_ped_req = 1'b0;
        at_neg(110);
        drain("pulse");

        // request held into walk, then pulsed during flash
        async_reset("rst_c");
        expect_obs("c_green",    4, 3'd0, 3'b001, 2'b01, 1'b0);
        expect_obs("c_wait",     6, 3'd0, 3'b001, 2'b01, 1'b1);
        expect_obs("c_yellow",  24, 3'd1, 3'b010, 2'b01, 1'b1);
        expect_obs("c_allred1", 36, 3'd2, 3'b100, 2'b01, 1'b1);
        expect_obs("c_walk",    40, 3'd3, 3'b100, 2'b10, 1'b0);
        expect_obs("c_flash1",  72, 3'd4, 3'b100, 2'b01, 1'b0);
        expect_obs("c_flreq",   74, 3'd4, 3'b100, 2'b01, 1'b1);
        expect_obs("c_flash2",  76, 3'd4, 3'b100, 2'b00, 1'b1);
        expect_obs("c_flash3",  80, 3'd4, 3'b100, 2'b01, 1'b1);
        expect_obs("c_flash4",  84, 3'd4, 3'b100, 2'b00, 1'b1);
        expect_obs("c_allred2", 88, 3'd5, 3'b100, 2'b01, 1'b1);
        expect_obs("c_green2",  92, 3'd0, 3'b001, 2'b01, 1'b1);
        expect_obs("c_yellow2",112, 3'd1, 3'b010, 2'b01, 1'b1);
        expect_obs("c_allred3",124, 3'd2, 3'b100, 2'b01, 1'b1);
        expect_obs("c_walk2",  128, 3'd3, 3'b100, 2'b10, 1'b0);
        at_neg(5);  tl4.i_w_ped_req = 1'b1;
        at_neg(50); tl4.i_w_ped_req = 1'b0;
        at_neg(73); tl4.i_w_ped_req = 1'b1;
        at_neg(74); tl4.i_w_ped_req = 1'b0;
        at_neg(140);
        drain("held");

        // reset mid-walk; prescaler restart shows as green 4 clocks later
        async_reset("rst_walk");
        expect_obs("d_green", 4, 3'd0, 3'b001, 2'b01, 1'b0);
`ifdef TL_NIGHT_MODE_EN
        expect_obs("n_night1", 12, 3'd6, 3'b010, 2'b00, 1'b0);
        expect_obs("n_night2", 16, 3'd6, 3'b000, 2'b00, 1'b0);
        expect_obs("n_night3", 20, 3'd6, 3'b010, 2'b00, 1'b0);
        expect_obs("n_allred", 24, 3'd5, 3'b100, 2'b01, 1'b0);
        expect_obs("n_green",  28, 3'd0, 3'b001, 2'b01, 1'b0);
`endif
        at_neg(9);  tl4.i_w_night = 1'b1;
        at_neg(21); tl4.i_w_night = 1'b0;
        at_neg(40);
        drain("night");

        // tick every third clock on the second instance, then safety sweep
        async_reset("rst_e");
        expect_obs("e_green", 4, 3'd0, 3'b001, 2'b01, 1'b0);
        at_neg(2);
        check_val("p3_allred_state", int'(tl3.o_r_state), 5);
        at_neg(3);
        check_val("p3_green_state", int'(tl3.o_r_state), 0);
        check_val("p3_green_car", int'(tl3.o_r_car), 1);
        inv_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            tl3.i_w_ped_req = 1'($urandom_range(0, 1));
        end
        inv_en = 1'b0;
        drain("sweep");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Pedestrian-crossing traffic-light controller.
- A free-running prescaler produces a 1-tick-per-second time base; a Moore FSM steps the car and pedestrian lamps through fixed, tick-counted phases.
- A latched pedestrian request drives the sequencing; lamp outputs go straight to board LEDs.

Parameters:
- P_CLK_PER_TICK, 100000000, clock cycles per tick (1 s at 100 MHz); legal range 2..2^32-1.
- P_MIN_GREEN, 5, minimum car-green ticks before a request is served; 1..255.
- P_YELLOW_TICKS, 3, car-yellow duration in ticks; 1..255.
- P_ALLRED_TICKS, 1, duration of each all-red interval in ticks; 1..255.
- P_WALK_TICKS, 8, pedestrian-walk duration in ticks; 1..255.
- P_FLASH_TICKS, 4, pedestrian flashing don't-walk duration in ticks; 1..255.

Ports:
- i_w_clk  input  1  system clock
- i_w_reset  input  1  asynchronous reset, active-low (0 = reset)
- i_w_ped_req  input  1  pedestrian button; level or pulse, sampled every clock
- i_w_night  input  1  night-mode request; used only with TL_NIGHT_MODE_EN
- o_r_car  output  3  car lamps {red, yellow, green}
- o_r_ped  output  2  pedestrian lamps {walk, dont_walk}
- o_r_ped_wait  output  1  request-pending indicator
- o_r_state  output  3  current state encoding, for debug

Behaviour:
- Reset: asynchronous, active-low. Applies immediately, including mid-phase.
  - State = S_ALL_RED2; tick timer = 0; prescaler = 0; pending = 0; blink = 1.
  - Outputs during reset: o_r_car=100, o_r_ped=01, o_r_ped_wait=0, o_r_state=5.
- Prescaler: 32-bit counter, 0..P_CLK_PER_TICK-1.
  - tick = 1 for exactly one cycle when the count equals P_CLK_PER_TICK-1; the counter then wraps to 0.
  - Free-running; never reset by state changes.
- Tick timer: 8 bits. Cleared on every state change. Otherwise increments on tick, saturating at 255.
- Timed-state exit: leave when (tick && timer == DUR-1). A state therefore lasts DUR ticks (the first partial tick counts).
- States, encodings, outputs and exits:
  - S_CAR_GREEN (0): car=001, ped=01. Exit to S_CAR_YELLOW on tick && pending && timer >= P_MIN_GREEN-1. With no request, stay indefinitely.
  - S_CAR_YELLOW (1): car=010, ped=01. After P_YELLOW_TICKS, go to S_ALL_RED1.
  - S_ALL_RED1 (2): car=100, ped=01. After P_ALLRED_TICKS, go to S_PED_WALK.
  - S_PED_WALK (3): car=100, ped=10. After P_WALK_TICKS, go to S_PED_FLASH.
  - S_PED_FLASH (4): car=100, ped={0,blink}. After P_FLASH_TICKS, go to S_ALL_RED2.
  - S_ALL_RED2 (5): car=100, ped=01. After P_ALLRED_TICKS, go to S_CAR_GREEN.
  - S_NIGHT (6): described under Optional Feature.
  - Encoding 7 is unreachable; if entered, go to S_ALL_RED2 on the next clock.
- blink: set to 1 on entry to S_PED_FLASH and S_NIGHT; toggles on every tick within those states.
- Pending request:
  - Set by i_w_ped_req=1 in states 0, 1, 2, 4, 5.
  - Ignored in S_PED_WALK.
  - Cleared on the clock that enters S_PED_WALK. If a request arrives in that same cycle, clear wins.
  - o_r_ped_wait = pending.
- Outputs: Moore decode of registered state plus blink only; no combinational input-to-output path.
- Safety invariant: walk=1 only while car=100. Car green and walk are never both 1.

Optional Feature:
- Macro: TL_NIGHT_MODE_EN.
- When defined:
  - i_w_night=1 moves any state to S_NIGHT on the next tick.
  - In S_NIGHT: car={0,blink,0}, ped=00; pending is held at 0.
  - When i_w_night=0, leave to S_ALL_RED2 (timer 0) on the next tick.
- When undefined:
  - i_w_night is ignored, S_NIGHT is never entered, and no S_NIGHT logic is generated.

Test Plan:
- Bench uses P_CLK_PER_TICK=4 and default durations for all scenarios.
- Release reset, no request -> S_ALL_RED2 for 1 tick (car=100), then S_CAR_GREEN held for 50 ticks; o_r_ped_wait=0 throughout.
- Single-cycle i_w_ped_req at green tick 1 -> o_r_ped_wait=1 next clock; green exits at tick 5. Then:
  - yellow for 3 ticks;
  - all-red for 1 tick;
  - walk (ped=10) for 8 ticks, with o_r_ped_wait=0 from walk entry;
  - flash for 4 ticks with ped pattern 01,00,01,00;
  - all-red for 1 tick, then green.
- Request held high through walk, released mid-walk -> pending stays 0 after walk entry; no second cycle. Request pulsed during flash -> second cycle starts after 5 green ticks.
- Assert i_w_reset=0 mid-walk, asynchronously between edges -> outputs immediately car=100, ped=01, wait=0, state=5; prescaler restarts at 0.
- Prescaler check with P_CLK_PER_TICK=3 -> tick every 3rd clock; over 300 clocks, assert the safety invariant and no encoding 7.
- TL_NIGHT_MODE_EN defined, i_w_night=1 during green -> S_NIGHT at next tick; car alternates 010/000 per tick, ped=00. Drop i_w_night -> S_ALL_RED2 at next tick. Undefined build: same stimulus, no state change.
